// File: rtl/rv32_mem_pkg.sv
// Shared funct3 encodings, controller FSM states and the byte-enable width.
// No logic; the misalignment helper is pure combinational.
package rv32_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    // Unsupported funct3 codes fall into the word case.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_LB, F3_LBU: return 1'b0;
            F3_LH, F3_LHU: return a[0];
            default:       return (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Word-addressed data-memory bus: controller drives strobes/address/data, memory returns data and a one-cycle ready.
// Strobes hold until MEM_READY; no other backpressure.
interface data_mem_ctrl_if
    import rv32_mem_pkg::*;
#(
    parameter int ADDR_W = 32
);
    logic              MEM_READ;
    logic              MEM_WRITE;
    logic [ADDR_W-3:0] MEM_ADDR;
    logic [31:0]       MEM_WDATA;
    logic [BE_W-1:0]   MEM_BYTEEN;
    logic [31:0]       MEM_RDATA;
    logic              MEM_READY;

    modport master (
        output MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WDATA, MEM_BYTEEN,
        input  MEM_RDATA, MEM_READY
    );

    modport slave (
        input  MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WDATA, MEM_BYTEEN,
        output MEM_RDATA, MEM_READY
    );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-enable generation, store lane replication and load lane extraction/extension.
// Purely combinational, zero latency.
module mem_lane_align
    import rv32_mem_pkg::*;
(
    input  logic [2:0]      i_func3,
    input  logic [1:0]      i_addr_lo,
    input  logic [31:0]     i_wdata,
    input  logic [31:0]     i_rdata,
    output logic [BE_W-1:0] o_byteen,
    output logic [31:0]     o_wdata,
    output logic [31:0]     o_rdata
);
    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_shift  = i_rdata >> {i_addr_lo, 3'b000};
        w_byte   = w_shift[7:0];
        w_half   = w_shift[15:0];
        o_byteen = 4'b1111;
        o_wdata  = i_wdata;
        o_rdata  = i_rdata;
        case (i_func3)
            F3_LB, F3_LBU: begin
                o_byteen = 4'b0001 << i_addr_lo;
                o_wdata  = {4{i_wdata[7:0]}};
                o_rdata  = (i_func3 == F3_LB) ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
            end
            F3_LH, F3_LHU: begin
                o_byteen = 4'b0011 << i_addr_lo;
                o_wdata  = {2{i_wdata[15:0]}};
                o_rdata  = (i_func3 == F3_LH) ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage controller: turns RV32 loads/stores into word transactions with byte enables.
// Stall = k+1 cycles for READY in cycle k; BUSYWAIT holds the pipeline until the cycle after MEM_READY.
module data_mem_ctrl
    import rv32_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              READ_IN,
    input  logic              WRITE_IN,
    input  logic [2:0]        FUNC3_IN,
    input  logic [ADDR_W-1:0] ADDR_IN,
    input  logic [31:0]       WDATA_IN,
    output logic              BUSYWAIT,
    output logic [31:0]       RDATA_OUT,
    output logic              MISALIGNED_OUT,
    data_mem_ctrl_if.master   mem_bus
);
    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_func3;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;

    logic              w_req;
    logic              w_req_mis;
    logic              w_busy;
    logic              w_mis;
    logic              w_latch;
    logic              w_capture;
    logic              w_mem_rd;
    logic              w_mem_wr;
    logic [BE_W-1:0]   w_byteen;
    logic [31:0]       w_wdata_rep;
    logic [31:0]       w_rdata_ext;

    assign w_req     = READ_IN | WRITE_IN;
    assign w_req_mis = is_misaligned(FUNC3_IN, ADDR_IN[1:0]);

    // Aligner works only on latched fields so the bus stays stable while the pipeline input may change.
    mem_lane_align u_align (
        .i_func3   (r_func3),
        .i_addr_lo (r_addr[1:0]),
        .i_wdata   (r_wdata),
        .i_rdata   (mem_bus.MEM_RDATA),
        .o_byteen  (w_byteen),
        .o_wdata   (w_wdata_rep),
        .o_rdata   (w_rdata_ext)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_mis       = 1'b0;
        w_latch     = 1'b0;
        w_capture   = 1'b0;
        w_mem_rd    = 1'b0;
        w_mem_wr    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (w_req_mis) begin
                        w_mis = 1'b1;
                    end else begin
                        w_busy      = 1'b1;
                        w_latch     = 1'b1;
                        w_state_nxt = WRITE_IN ? ST_WRITE : ST_READ;
                    end
                end
            end
            ST_READ: begin
                w_busy   = 1'b1;
                w_mem_rd = 1'b1;
                if (mem_bus.MEM_READY) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_WRITE: begin
                w_busy   = 1'b1;
                w_mem_wr = 1'b1;
                if (mem_bus.MEM_READY) w_state_nxt = ST_DONE;
            end
            // Inputs still carry the finished instruction here, so they are not looked at.
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_func3 <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_addr  <= ADDR_IN;
                r_func3 <= FUNC3_IN;
                r_wdata <= WDATA_IN;
            end
            if (w_capture) r_rdata <= w_rdata_ext;
        end
    end

    // IDLE-cycle stall is combinational on the request, so mask it while reset is asserted.
    assign BUSYWAIT           = RESET & w_busy;
    assign MISALIGNED_OUT     = RESET & w_mis;
    assign RDATA_OUT          = r_rdata;
    assign mem_bus.MEM_READ   = w_mem_rd;
    assign mem_bus.MEM_WRITE  = w_mem_wr;
    assign mem_bus.MEM_ADDR   = r_addr[ADDR_W-1:2];
    assign mem_bus.MEM_WDATA  = w_wdata_rep;
    assign mem_bus.MEM_BYTEEN = w_byteen;

endmodule
